rx_data_controller: RTL and testbench

//  Receive-side framing controller: inverse of the TX data controller. Consumes the decoded lane

---
 rtl/aurora_pkg.sv | 16 +
 rtl/rx_frame_stats.sv | 29 ++
 rtl/rx_data_controller.sv | 157 +++++++++++++++
 tb/tb_rx_data_controller.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_pkg.sv
// rtl/aurora_pkg.sv - shared Aurora lane types and RX framing parameter defaults
package aurora_pkg;

  localparam int AXI_DATA_SIZE = 32;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    SCP  = 2'd1,
    ECP  = 2'd2,
    I    = 2'd3
  } ordered_sets_e;

  localparam int RX_MAX_WORDS_DEF = 256;
  localparam int RX_STATS_W_DEF   = 16;

endpackage

// File: rtl/rx_frame_stats.sv
// rtl/rx_frame_stats.sv - saturating good-frame and error counters for the RX framer
module rx_frame_stats #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_ok_i,
  input  logic             frame_err_i,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  logic [CNT_W-1:0] frame_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (frame_ok_i && (frame_cnt_q != '1)) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (frame_err_i && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: rtl/rx_data_controller.sv
// rtl/rx_data_controller.sv - RX framer: lane ordered sets + data to AXI-S frames
// Optional statistics counters are built only when RX_STATS_EN is defined.
module rx_data_controller
  import aurora_pkg::*;
#(
  parameter int MAX_WORDS = RX_MAX_WORDS_DEF,
  parameter int CNT_W     = RX_STATS_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lane_up,
  input  ordered_sets_e            ordered_sets,
  input  logic [AXI_DATA_SIZE-1:0] data_in,
  output logic                     m_axi_valid,
  output logic                     m_axi_last,
  output logic [AXI_DATA_SIZE-1:0] m_axi_data,
`ifdef RX_STATS_EN
  output logic [CNT_W-1:0]         frame_cnt,
  output logic [CNT_W-1:0]         err_cnt,
`endif
  output logic                     frame_err
);

  localparam int WCW = $clog2(MAX_WORDS + 1);
  localparam logic [WCW-1:0] WORD_MAX = WCW'(MAX_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STREAM  = 2'd1,
    ST_DISCARD = 2'd2
  } rx_state_e;

  rx_state_e                state_q;
  logic                     hold_vld_q;
  logic [AXI_DATA_SIZE-1:0] hold_data_q;
  logic [WCW-1:0]           word_cnt_q;
  logic                     valid_q;
  logic                     last_q;
  logic [AXI_DATA_SIZE-1:0] data_q;
  logic                     frame_err_q;
  logic                     frame_ok_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      word_cnt_q  <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      data_q      <= '0;
      frame_err_q <= 1'b0;
      frame_ok_q  <= 1'b0;
    end else begin
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      data_q      <= '0;
      frame_err_q <= 1'b0;
      frame_ok_q  <= 1'b0;
      // Losing the lane beats any symbol seen in the same cycle.
      if (!lane_up) begin
        frame_err_q <= (state_q != ST_IDLE);
        state_q     <= ST_IDLE;
        hold_vld_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            case (ordered_sets)
              SCP: begin
                state_q    <= ST_STREAM;
                word_cnt_q <= '0;
                hold_vld_q <= 1'b0;
              end
              ECP:     frame_err_q <= 1'b1;
              default: ;
            endcase
          end
          ST_STREAM: begin
            case (ordered_sets)
              NONE: begin
                if (word_cnt_q == WORD_MAX) begin
                  frame_err_q <= 1'b1;
                  hold_vld_q  <= 1'b0;
                  state_q     <= ST_DISCARD;
                end else begin
                  // The held word goes out only once we know it is not the last one.
                  if (hold_vld_q) begin
                    valid_q <= 1'b1;
                    data_q  <= hold_data_q;
                  end
                  hold_data_q <= data_in;
                  hold_vld_q  <= 1'b1;
                  word_cnt_q  <= word_cnt_q + 1'b1;
                end
              end
              ECP: begin
                if (hold_vld_q) begin
                  valid_q    <= 1'b1;
                  last_q     <= 1'b1;
                  data_q     <= hold_data_q;
                  frame_ok_q <= 1'b1;
                end else begin
                  frame_err_q <= 1'b1;
                end
                state_q    <= ST_IDLE;
                hold_vld_q <= 1'b0;
              end
              SCP: begin
                frame_err_q <= 1'b1;
                hold_vld_q  <= 1'b0;
                word_cnt_q  <= '0;
              end
              default: ;
            endcase
          end
          ST_DISCARD: begin
            case (ordered_sets)
              ECP: state_q <= ST_IDLE;
              SCP: begin
                state_q    <= ST_STREAM;
                word_cnt_q <= '0;
                hold_vld_q <= 1'b0;
              end
              default: ;
            endcase
          end
          default: begin
            state_q    <= ST_IDLE;
            hold_vld_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign m_axi_valid = valid_q;
  assign m_axi_last  = last_q;
  assign m_axi_data  = data_q;
  assign frame_err   = frame_err_q;

`ifdef RX_STATS_EN
  rx_frame_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk        (clk),
    .rst        (rst),
    .frame_ok_i (frame_ok_q),
    .frame_err_i(frame_err_q),
    .frame_cnt_o(frame_cnt),
    .err_cnt_o  (err_cnt)
  );
`else
  logic unused_ok;
  assign unused_ok = frame_ok_q;
`endif

endmodule

// File: tb/tb_rx_data_controller.sv
// tb/tb_rx_data_controller.sv - scoreboard bench for rx_data_controller (MAX_WORDS=4)
module tb_rx_data_controller;
  import aurora_pkg::*;

  localparam int MW = 4;
  localparam int CW = 16;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     lane_up = 1'b0;
  ordered_sets_e            ordered_sets = NONE;
  logic [AXI_DATA_SIZE-1:0] data_in = '0;
  logic                     m_axi_valid;
  logic                     m_axi_last;
  logic [AXI_DATA_SIZE-1:0] m_axi_data;
  logic                     frame_err;
`ifdef RX_STATS_EN
  logic [CW-1:0]            frame_cnt;
  logic [CW-1:0]            err_cnt;
`endif

  rx_data_controller #(.MAX_WORDS(MW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .lane_up     (lane_up),
    .ordered_sets(ordered_sets),
    .data_in     (data_in),
    .m_axi_valid (m_axi_valid),
    .m_axi_last  (m_axi_last),
    .m_axi_data  (m_axi_data),
`ifdef RX_STATS_EN
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt),
`endif
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [AXI_DATA_SIZE:0] exp_q[$];
  logic [AXI_DATA_SIZE:0] obs_q[$];
  int err_pulses = 0;
  int viol = 0;
  int exp_frames = 0;
  int exp_errs = 0;

  task automatic cyc(input logic lu, input ordered_sets_e os, input logic [AXI_DATA_SIZE-1:0] d);
    lane_up = lu;
    ordered_sets = os;
    data_in = d;
    @(posedge clk);
    #1;
    if (m_axi_valid) obs_q.push_back({m_axi_last, m_axi_data});
    if (frame_err) err_pulses++;
    if (!m_axi_valid && (m_axi_last || m_axi_data != '0)) viol++;
  endtask

  task automatic expect_word(input logic last, input logic [AXI_DATA_SIZE-1:0] d);
    exp_q.push_back({last, d});
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_axi_valid, m_axi_last, frame_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000", {m_axi_valid, m_axi_last, frame_err});
    end
    checks++;
    if (m_axi_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", m_axi_data);
    end
`ifdef RX_STATS_EN
    checks++;
    if (frame_cnt !== '0 || err_cnt !== '0) begin
      errors++;
      $display("FAIL reset_stats: got %0d/%0d expected 0/0", frame_cnt, err_cnt);
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, NONE, 32'h0);
  endtask

  task automatic test_empty_frame;
    err_pulses = 0;
    cyc(1'b1, SCP, 32'h0);
    cyc(1'b1, ECP, 32'h0);
    cyc(1'b1, NONE, 32'h0);
    exp_errs += 1;
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL empty_words: got %0d expected 0", obs_q.size());
    end
    checks++;
    if (err_pulses != 1) begin
      errors++;
      $display("FAIL empty_err: got %0d expected 1", err_pulses);
    end
`ifdef RX_STATS_EN
    checks++;
    if (err_cnt !== CW'(1) || frame_cnt !== '0) begin
      errors++;
      $display("FAIL empty_stats: got %0d/%0d expected 0/1", frame_cnt, err_cnt);
    end
`endif
    obs_q.delete();
  endtask

  task automatic test_basic;
    logic [AXI_DATA_SIZE:0] e, o;
    err_pulses = 0;
    cyc(1'b1, SCP, 32'h0);
    cyc(1'b1, NONE, 32'hA1A1_0001); expect_word(1'b0, 32'hA1A1_0001);
    cyc(1'b1, NONE, 32'hA2A2_0002); expect_word(1'b0, 32'hA2A2_0002);
    cyc(1'b1, NONE, 32'hA3A3_0003); expect_word(1'b1, 32'hA3A3_0003);
    cyc(1'b1, ECP, 32'hDEAD_BEEF);
    cyc(1'b1, NONE, 32'h0);
    exp_frames += 1;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL basic_word: got %h expected %h", o, e);
      end
    end
    checks++;
    if (err_pulses != 0) begin
      errors++;
      $display("FAIL basic_err: got %0d expected 0", err_pulses);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_idle_in_frame;
    logic [AXI_DATA_SIZE:0] e, o;
    err_pulses = 0;
    cyc(1'b1, SCP, 32'h0);
    cyc(1'b1, NONE, 32'hB1B1_0001); expect_word(1'b0, 32'hB1B1_0001);
    cyc(1'b1, I, 32'h1111_1111);
    cyc(1'b1, I, 32'h2222_2222);
    cyc(1'b1, NONE, 32'hB2B2_0002); expect_word(1'b1, 32'hB2B2_0002);
    cyc(1'b1, ECP, 32'h0);
    cyc(1'b1, NONE, 32'h0);
    exp_frames += 1;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL idle_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL idle_word: got %h expected %h", o, e);
      end
    end
    checks++;
    if (err_pulses != 0) begin
      errors++;
      $display("FAIL idle_err: got %0d expected 0", err_pulses);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_max_words;
    logic [AXI_DATA_SIZE:0] e, o;
    err_pulses = 0;
    cyc(1'b1, SCP, 32'h0);
    for (int k = 1; k <= MW; k++) begin
      cyc(1'b1, NONE, 32'h4400_0000 + k);
      expect_word(k == MW, 32'h4400_0000 + k);
    end
    cyc(1'b1, ECP, 32'h0);
    cyc(1'b1, NONE, 32'h0);
    exp_frames += 1;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL max_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL max_word: got %h expected %h", o, e);
      end
    end
    checks++;
    if (err_pulses != 0) begin
      errors++;
      $display("FAIL max_err: got %0d expected 0", err_pulses);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_overflow;
    logic [AXI_DATA_SIZE:0] e, o;
    err_pulses = 0;
    cyc(1'b1, SCP, 32'h0);
    for (int k = 1; k <= MW + 1; k++) begin
      cyc(1'b1, NONE, 32'hC0C0_0000 + k);
      if (k < MW) expect_word(1'b0, 32'hC0C0_0000 + k);
    end
    cyc(1'b1, NONE, 32'hC0C0_00FF);
    cyc(1'b1, ECP, 32'h0);
    cyc(1'b1, SCP, 32'h0);
    cyc(1'b1, NONE, 32'hD1D1_0001); expect_word(1'b1, 32'hD1D1_0001);
    cyc(1'b1, ECP, 32'h0);
    cyc(1'b1, NONE, 32'h0);
    exp_frames += 1;
    exp_errs += 1;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL ovf_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL ovf_word: got %h expected %h", o, e);
      end
    end
    checks++;
    if (err_pulses != 1) begin
      errors++;
      $display("FAIL ovf_err: got %0d expected 1", err_pulses);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [AXI_DATA_SIZE:0] e, o;
    err_pulses = 0;
    cyc(1'b1, SCP, 32'h0);
    cyc(1'b1, NONE, 32'hE1E1_0001); expect_word(1'b0, 32'hE1E1_0001);
    cyc(1'b1, NONE, 32'hE2E2_0002);
    cyc(1'b1, SCP, 32'h0);
    cyc(1'b1, NONE, 32'hF1F1_0001); expect_word(1'b1, 32'hF1F1_0001);
    cyc(1'b1, ECP, 32'h0);
    cyc(1'b1, NONE, 32'h0);
    exp_frames += 1;
    exp_errs += 1;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b_word: got %h expected %h", o, e);
      end
    end
    checks++;
    if (err_pulses != 1) begin
      errors++;
      $display("FAIL b2b_err: got %0d expected 1", err_pulses);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_lane_down;
    logic [AXI_DATA_SIZE:0] e, o;
    err_pulses = 0;
    cyc(1'b1, SCP, 32'h0);
    cyc(1'b1, NONE, 32'h6161_0001); expect_word(1'b0, 32'h6161_0001);
    cyc(1'b1, NONE, 32'h6262_0002);
    cyc(1'b0, NONE, 32'h6363_0003);
    cyc(1'b1, ECP, 32'h0);
    cyc(1'b1, NONE, 32'h0);
    exp_errs += 2;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL lane_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL lane_word: got %h expected %h", o, e);
      end
    end
    checks++;
    if (err_pulses != 2) begin
      errors++;
      $display("FAIL lane_err: got %0d expected 2", err_pulses);
    end
`ifdef RX_STATS_EN
    checks++;
    if (frame_cnt !== CW'(exp_frames) || err_cnt !== CW'(exp_errs)) begin
      errors++;
      $display("FAIL lane_stats: got %0d/%0d expected %0d/%0d", frame_cnt, err_cnt, exp_frames, exp_errs);
    end
`endif
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_midframe_reset;
    logic [AXI_DATA_SIZE:0] e, o;
    err_pulses = 0;
    cyc(1'b1, SCP, 32'h0);
    cyc(1'b1, NONE, 32'h9191_0001);
    cyc(1'b1, NONE, 32'h9292_0002); expect_word(1'b0, 32'h9191_0001);
    rst = 1'b1;
    #1;
    checks++;
    if ({m_axi_valid, m_axi_last, frame_err} !== 3'b000 || m_axi_data !== '0) begin
      errors++;
      $display("FAIL rst_mid_out: got %b/%h expected 000/0", {m_axi_valid, m_axi_last, frame_err}, m_axi_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_frames = 0;
    exp_errs = 0;
    cyc(1'b1, NONE, 32'h9393_0003);
    cyc(1'b1, NONE, 32'h9494_0004);
    cyc(1'b1, SCP, 32'h0);
    cyc(1'b1, NONE, 32'h9595_0005); expect_word(1'b1, 32'h9595_0005);
    cyc(1'b1, ECP, 32'h0);
    cyc(1'b1, NONE, 32'h0);
    exp_frames += 1;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rst_mid_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rst_mid_word: got %h expected %h", o, e);
      end
    end
    checks++;
    if (err_pulses != 0) begin
      errors++;
      $display("FAIL rst_mid_err: got %0d expected 0", err_pulses);
    end
`ifdef RX_STATS_EN
    checks++;
    if (frame_cnt !== CW'(exp_frames) || err_cnt !== CW'(exp_errs)) begin
      errors++;
      $display("FAIL rst_mid_stats: got %0d/%0d expected %0d/%0d", frame_cnt, err_cnt, exp_frames, exp_errs);
    end
`endif
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL idle_outputs: got %0d stray last/data cycles expected 0", viol);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_empty_frame();
    test_basic();
    test_idle_in_frame();
    test_max_words();
    test_overflow();
    test_back_to_back();
    test_lane_down();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
